// File: rtl/adc_spi_responder.sv
// SPI responder model of a 12-bit multi-channel ADC (ADC128S022-style).
// Optional dither on the returned sample is enabled with `define ADC_RESP_NOISE_EN.
module adc_spi_responder #(
  parameter int NUM_CH     = 8,
  parameter int DATA_BITS  = 12,
  parameter int FRAME_BITS = 16
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic                        adc_cs_n,
  input  logic                        adc_sclk,
  input  logic                        adc_din,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_values,
  output logic                        adc_data_out,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic [2:0]                  cur_channel
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [2:0]              addr_q, addr_d;
  logic [2:0]              chan_q, chan_d;
  logic                    miso_q, miso_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic din_meta_q, din_sync_q;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [DATA_BITS-1:0] sample, capture;

  function automatic logic [DATA_BITS-1:0] sel_sample(
    input logic [NUM_CH*DATA_BITS-1:0] vals,
    input logic [2:0]                  ch
  );
    sel_sample = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (int'(ch) == n) sel_sample = vals[n*DATA_BITS +: DATA_BITS];
  endfunction

  assign cs_fall   =  cs_prev_q   & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q   &  cs_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;
  assign sample    = sel_sample(ch_values, chan_q);

`ifdef ADC_RESP_NOISE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per completed frame
  always_ff @(posedge clk) begin
    if (sys_rst)     lfsr_q <= 16'hACE1;
    else if (done_d) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign capture = sample ^ {{(DATA_BITS-2){1'b0}}, lfsr_q[1:0]};
`else
  assign capture = sample;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    chan_d    = chan_q;
    miso_d    = miso_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          shift_d   = {{(FRAME_BITS-DATA_BITS){1'b0}}, capture};
          bit_cnt_d = '0;
          addr_d    = '0;
          miso_d    = shift_d[FRAME_BITS-1];
          state_d   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          if (bit_cnt_q >= CNT_W'(2) && bit_cnt_q <= CNT_W'(4))
            addr_d = {addr_q[1:0], din_sync_q};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            chan_d  = addr_q;
            miso_d  = 1'b0;
            state_d = S_DONE;
          end
        end else if (sclk_fall && bit_cnt_q != '0) begin
          // The fall ahead of the first rise (SCLK idles high) must keep the MSB on the line
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          miso_d  = shift_q[FRAME_BITS-2];
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b1;
      sclk_sync_q <= 1'b1;
      sclk_prev_q <= 1'b1;
      din_meta_q  <= 1'b0;
      din_sync_q  <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      chan_q      <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_meta_q   <= adc_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= adc_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      din_meta_q  <= adc_din;
      din_sync_q  <= din_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    addr_q  <= addr_d;
  end

  assign adc_data_out = miso_q;
  assign frame_done   = done_q;
  assign frame_error  = err_q;
  assign cur_channel  = chan_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames as a master and checks MISO words and pulses.
module tb_adc_spi_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic [95:0] ch_values;
  logic        adc_data_out;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  cur_channel;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_edge = 0;
  int edge_no  = 0;
  int done_base, err_base;
  logic [31:0] rx;
  logic [15:0] exp_w;

  always #10 clk = ~clk;

  adc_spi_responder dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .ch_values    (ch_values),
    .adc_data_out (adc_data_out),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .cur_channel  (cur_channel)
  );

  always @(negedge clk) begin
    if (frame_done) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= edge_no;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
  end

`ifdef ADC_RESP_NOISE_EN
  logic [15:0] lfsr_m = 16'hACE1;
  task automatic lfsr_step();
    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  endtask
  task automatic lfsr_reset();
    lfsr_m = 16'hACE1;
  endtask
  function automatic logic [15:0] exp_word(input logic [11:0] v);
    return {4'h0, v ^ {10'b0, lfsr_m[1:0]}};
  endfunction
`else
  task automatic lfsr_step();
  endtask
  task automatic lfsr_reset();
  endtask
  function automatic logic [15:0] exp_word(input logic [11:0] v);
    return {4'h0, v};
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master frame: CS low, nedges SCLK cycles (fall then rise), MISO sampled at each rise
  task automatic spi_frame(input logic [2:0] addr, input int nedges, input bit end_cs,
                           output logic [31:0] word);
    logic [2:0] a;
    a = addr;
    word = '0;
    adc_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < nedges; e++) begin
      adc_sclk = 1'b0;
      if (e >= 2 && e <= 4) begin
        adc_din = a[2];
        a = {a[1:0], 1'b0};
      end else begin
        adc_din = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      word = {word[30:0], adc_data_out};
      adc_sclk = 1'b1;
      edge_no = e + 1;
      repeat (HALF) @(negedge clk);
    end
    if (end_cs) begin
      adc_cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    adc_cs_n  = 1'b1;
    adc_sclk  = 1'b1;
    adc_din   = 1'b0;
    ch_values = {12'h777, 12'h666, 12'h555, 12'h444, 12'h111, 12'h321, 12'h5A5, 12'hABC};
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(adc_data_out), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_err",  32'(frame_error), 32'h0);
    check("rst_chan", 32'(cur_channel), 32'h0);
    sys_rst = 1'b0;
    repeat (4) @(negedge clk);

    // Full frame from channel 0
    done_base = done_cnt; err_base = err_cnt;
    exp_w = exp_word(12'hABC);
    spi_frame(3'b000, 16, 1'b1, rx);
    check("t1_word", 32'(rx[15:0]), 32'(exp_w));
    check("t1_done", 32'(done_cnt - done_base), 32'd1);
    check("t1_err",  32'(err_cnt - err_base), 32'd0);
    check("t1_chan", 32'(cur_channel), 32'd0);
    lfsr_step();

    // Address for next frame takes effect one frame later
    exp_w = exp_word(12'hABC);
    spi_frame(3'b001, 16, 1'b1, rx);
    check("t2a_word", 32'(rx[15:0]), 32'(exp_w));
    check("t2a_chan", 32'(cur_channel), 32'd1);
    lfsr_step();
    exp_w = exp_word(12'h5A5);
    spi_frame(3'b000, 16, 1'b1, rx);
    check("t2b_word", 32'(rx[15:0]), 32'(exp_w));
    check("t2b_chan", 32'(cur_channel), 32'd0);
    lfsr_step();

    // Short frame aborted by CS
    done_base = done_cnt; err_base = err_cnt;
    spi_frame(3'b010, 7, 1'b1, rx);
    check("t3_err",  32'(err_cnt - err_base), 32'd1);
    check("t3_done", 32'(done_cnt - done_base), 32'd0);
    check("t3_chan", 32'(cur_channel), 32'd0);
    check("t3_miso", 32'(adc_data_out), 32'd0);

    // Overlong frame: extra edges ignored
    done_base = done_cnt;
    exp_w = exp_word(12'hABC);
    spi_frame(3'b011, 20, 1'b1, rx);
    check("t4_word", 32'(rx[19:4]), 32'(exp_w));
    check("t4_tail", 32'(rx[3:0]), 32'h0);
    check("t4_done", 32'(done_cnt - done_base), 32'd1);
    check("t4_edge", 32'(done_edge), 32'd16);
    check("t4_chan", 32'(cur_channel), 32'd3);
    lfsr_step();

    // Channel value changed mid-frame
    exp_w = exp_word(12'h111);
    fork
      spi_frame(3'b011, 16, 1'b1, rx);
      begin
        repeat (60) @(negedge clk);
        ch_values[3*12 +: 12] = 12'h222;
      end
    join
    check("t5a_word", 32'(rx[15:0]), 32'(exp_w));
    lfsr_step();
    exp_w = exp_word(12'h222);
    spi_frame(3'b011, 16, 1'b1, rx);
    check("t5b_word", 32'(rx[15:0]), 32'(exp_w));
    lfsr_step();

    // Reset in the middle of a frame
    done_base = done_cnt; err_base = err_cnt;
    spi_frame(3'b110, 9, 1'b0, rx);
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    check("t6_miso", 32'(adc_data_out), 32'h0);
    check("t6_done", 32'(frame_done), 32'h0);
    check("t6_err",  32'(frame_error), 32'h0);
    check("t6_chan", 32'(cur_channel), 32'h0);
    adc_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    sys_rst = 1'b0;
    lfsr_reset();
    repeat (6) @(negedge clk);
    check("t6_nopulse_err",  32'(err_cnt - err_base), 32'd0);
    check("t6_nopulse_done", 32'(done_cnt - done_base), 32'd0);
    exp_w = exp_word(12'hABC);
    spi_frame(3'b101, 16, 1'b1, rx);
    check("t6_word", 32'(rx[15:0]), 32'(exp_w));
    check("t6_next_chan", 32'(cur_channel), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
